// File: rtl/reg_dump_if.sv
// Stream interface for register dump beats.
// The master drives valid/data/addr/last and the slave drives ready.
interface reg_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_addr, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_addr, input m_last, output m_ready);
endinterface

// File: rtl/reg_dump_reader.sv
// Register-file dump reader.
// After a start pulse, walks an address window through one register-file
// read port. Each value is streamed out as one valid/ready beat, tagged
// with its address and a last flag. Abort ends the dump early. A done
// pulse marks the end of every dump, whether it completed or was aborted.
module reg_dump_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    reg_dump_if.master        m,
    output logic              busy,
    output logic              done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_d;
    logic [ADDR_W:0]     remain_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                done_q;
    logic                accept;
    logic                load;

    // The sink takes the current beat.
    assign accept = valid_q && m.m_ready;

    // Fetch the next register when the output slot is empty or is emptying now.
    assign load = (state_q == RUN) && (remain_q != '0) && (!valid_q || m.m_ready);

    // Address walk wraps at the top of the register file.
    assign ptr_d = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    // The read port address is the walk pointer itself, so it is registered and holds in IDLE.
    assign rf_rd_addr = ptr_q;
    assign m.m_valid  = valid_q;
    assign m.m_data   = data_q;
    assign m.m_addr   = addr_q;
    assign m.m_last   = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            remain_q <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q    <= start_addr;
                        remain_q <= (count == '0) ? (ADDR_W+1)'(NUM_REGS) : count;
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Any pending beat is dropped.
                        valid_q  <= 1'b0;
                        last_q   <= 1'b0;
                        remain_q <= '0;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (accept && last_q) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (load) begin
                        data_q   <= rf_rd_data;
                        addr_q   <= ptr_q;
                        valid_q  <= 1'b1;
                        last_q   <= (remain_q == (ADDR_W+1)'(1));
                        ptr_q    <= ptr_d;
                        remain_q <= remain_q - 1'b1;
                    end else if (accept) begin
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader.
// Expected beats are queued when a dump is started. A monitor pops and
// compares every accepted beat.
module tb_reg_dump_reader;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   count = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [NR];
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;

    reg_dump_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    reg_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .m          (m_if.master),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write visible from the next cycle.
    assign rf_rd_data = rf[rf_rd_addr];
    always @(posedge clk) if (we) rf[waddr] <= wdata;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    beats = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a window is a list of (address mod 32, current content, last flag).
    task automatic push_window(input int sa, input int cnt);
        int    n;
        beat_t b;
        n = (cnt == 0) ? NR : cnt;
        for (int k = 0; k < n; k++) begin
            b.a = AW'((sa + k) % NR);
            b.d = rf[(sa + k) % NR];
            b.l = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic write_reg(input int a, input logic [DW-1:0] d);
        we = 1'b1; waddr = AW'(a); wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic do_start(input int sa, input int cnt);
        push_window(sa, cnt);
        start = 1'b1; start_addr = AW'(sa); count = (AW+1)'(cnt);
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("no_valid_edge1", m_if.m_valid, 0);
        tick();
        chk("first_valid_edge2", m_if.m_valid, 1);
    endtask

    task automatic wait_done(input bit rnd, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            if (rnd) m_if.m_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        chk("done_seen", done, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_clear", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        m_if.m_ready = 1'b1;
    endtask

    // Monitor: compare accepted beats against the queue and check holding while stalled.
    logic  stall_prev = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = '{a: m_if.m_addr, d: m_if.m_data, l: m_if.m_last};
        if (rst_n) begin
            if (stall_prev)
                chk("stall_hold", {m_if.m_valid, cur}, {1'b1, held});
            if (m_if.m_valid && m_if.m_ready && !abort) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {1'b1, cur}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", cur, e);
                end
            end
            stall_prev = m_if.m_valid && !m_if.m_ready && !abort;
            held = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int b0;
        int sa;
        int cnt;
        m_if.m_ready = 1'b1;
        #1;
        chk("rst_outputs", {rf_rd_addr, m_if.m_data, m_if.m_addr, m_if.m_valid, m_if.m_last, busy, done}, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) write_reg(i, DW'(i * 32'h11));

        // Full 32-register dump at full rate.
        b0 = beats;
        do_start(0, 0);
        wait_done(1'b0, cyc);
        chk("t1_cycles", cyc, 32);
        chk("t1_beats", beats - b0, 32);

        // Window wrapping past the top address.
        b0 = beats;
        do_start(30, 4);
        wait_done(1'b0, cyc);
        chk("t2_beats", beats - b0, 4);

        // Backpressure pattern.
        b0 = beats;
        do_start(7, 3);
        begin
            bit pat [6] = '{1, 0, 0, 1, 0, 1};
            for (int i = 0; i < 6; i++) begin
                m_if.m_ready = pat[i];
                tick();
            end
        end
        wait_done(1'b0, cyc);
        chk("t3_beats", beats - b0, 3);

        // Abort mid-dump, then restart.
        do_start(0, 0);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", m_if.m_valid, 0);
        chk("abort_done", done, 1);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        tick();
        chk("abort_done_pulse", done, 0);
        b0 = beats;
        do_start(3, 2);
        wait_done(1'b0, cyc);
        chk("restart_beats", beats - b0, 2);

        // Start while busy is ignored.
        b0 = beats;
        do_start(0, 5);
        start = 1'b1; start_addr = 5'd10; count = 6'd1;
        tick();
        start = 1'b0;
        wait_done(1'b0, cyc);
        chk("t5_beats", beats - b0, 5);

        // Reset mid-dump.
        do_start(0, 0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {rf_rd_addr, m_if.m_data, m_if.m_addr, m_if.m_valid, m_if.m_last, busy, done}, '0);
        tick();
        chk("rst_no_done", done, 0);
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        // Same-cycle write is not visible to the load.
        push_window(5, 1);
        start = 1'b1; start_addr = 5'd5; count = 6'd1;
        tick();
        start = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        chk("t6_first_valid", m_if.m_valid, 1);
        wait_done(1'b0, cyc);
        chk("t6_rf_written", rf[5], 32'hDEADBEEF);
        do_start(5, 1);
        wait_done(1'b0, cyc);

        // Random windows, random register contents, random backpressure.
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 6; w++) write_reg($urandom_range(0, NR - 1), $urandom);
            sa  = $urandom_range(0, NR - 1);
            cnt = $urandom_range(0, NR);
            b0  = beats;
            m_if.m_ready = 1'b1;
            do_start(sa, cnt);
            wait_done(1'b1, cyc);
            chk("rand_beats", beats - b0, (cnt == 0) ? NR : cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
